// File: rtl/conv_encoder_param.sv
// Rate-1/N_OUT feed-forward convolutional encoder, one bit per clock, with tail-biting
// and zero-terminated block modes on valid/ready byte streams.
module conv_encoder_param #(
   parameter int unsigned    K             = 7,
   parameter int unsigned    N_OUT         = 3,
   parameter logic [K-1:0]   G0            = 7'o133,
   parameter logic [K-1:0]   G1            = 7'o171,
   parameter logic [K-1:0]   G2            = 7'o165,
   parameter logic [K-1:0]   G3            = 7'o000,
   parameter int unsigned    LEN_W         = 10,
   parameter int unsigned    MAX_LEN_BYTES = 768
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               mode_i,
   input  logic [LEN_W-1:0]   len_bytes_i,
   input  logic [K-2:0]       tail_in_i,
   input  logic [7:0]         in_data_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   output logic [8*N_OUT-1:0] out_data_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic               out_last_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_len_o
);

   localparam logic [3:0][K-1:0] Gen        = {G3, G2, G1, G0};
   localparam int unsigned       FlushSlots = 8 * ((K + 6) / 8);
   localparam int unsigned       FcW        = $clog2(FlushSlots);

   typedef enum logic [1:0] {StIdle, StEnc, StFlush, StDrain} state_e;

   state_e             state_q, state_d;
   logic               mode_q, mode_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   bytes_acc_q, bytes_acc_d;
   logic [LEN_W-1:0]   enc_bytes_q, enc_bytes_d;
   logic [7:0]         in_byte_q, in_byte_d;
   logic               in_full_q, in_full_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   // st_q[d-1] holds delay-d bit s[d], same layout as tail_in_i
   logic [K-2:0]       st_q, st_d;
   logic [8*N_OUT-1:0] asm_q, asm_d;
   logic [2:0]         asm_cnt_q, asm_cnt_d;
   logic [FcW-1:0]     flush_cnt_q, flush_cnt_d;
   logic [8*N_OUT-1:0] out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
   logic               done_q, done_d;
   logic               err_len_q, err_len_d;

   logic               u, pad, stall, step, bit_avail, grp_done, out_accept;
   logic               last_enc_bit, flush_last, in_ready, in_accept, len_ok;
   logic [K-1:0]       taps;
   logic [N_OUT-1:0]   lane_bits;

   always_comb begin
      out_accept   = out_valid_q & out_ready_i;
      u            = (state_q == StEnc) ? in_byte_q[bit_idx_q] : 1'b0;
      pad          = (state_q == StFlush) && (32'(flush_cnt_q) >= K - 1);
      bit_avail    = ((state_q == StEnc) && in_full_q) || (state_q == StFlush);
      grp_done     = (asm_cnt_q == 3'd7);
      stall        = grp_done & out_valid_q & ~out_ready_i;
      step         = bit_avail & ~stall;
      last_enc_bit = (state_q == StEnc) && (bit_idx_q == 3'd0) &&
                     (enc_bytes_q == len_q - LEN_W'(1));
      flush_last   = (flush_cnt_q == FcW'(FlushSlots - 1));
      in_ready     = (state_q == StEnc) && (bytes_acc_q != len_q) &&
                     (!in_full_q || (step && bit_idx_q == 3'd0));
      in_accept    = in_ready & in_valid_i;
      len_ok       = (len_bytes_i != '0) && (32'(len_bytes_i) <= MAX_LEN_BYTES);

      taps      = '0;
      taps[K-1] = u;
      for (int unsigned d = 1; d < K; d++) begin
         taps[K-1-d] = st_q[d-1];
      end
      lane_bits = '0;
      for (int unsigned j = 0; j < N_OUT; j++) begin
         lane_bits[j] = pad ? 1'b0 : ^(Gen[j] & taps);
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      len_d       = len_q;
      bytes_acc_d = bytes_acc_q;
      enc_bytes_d = enc_bytes_q;
      in_byte_d   = in_byte_q;
      in_full_d   = in_full_q;
      bit_idx_d   = bit_idx_q;
      st_d        = st_q;
      asm_d       = asm_q;
      asm_cnt_d   = asm_cnt_q;
      flush_cnt_d = flush_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      err_len_d   = 1'b0;

      if (out_accept) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (step) begin
         if (!pad) begin
            st_d = {st_q[K-3:0], u};
         end
         for (int unsigned j = 0; j < N_OUT; j++) begin
            asm_d[8*j +: 8] = {asm_q[8*j +: 7], lane_bits[j]};
         end
         asm_cnt_d = asm_cnt_q + 3'd1;
         if (grp_done) begin
            out_data_d  = asm_d;
            out_valid_d = 1'b1;
            out_last_d  = (last_enc_bit && !mode_q) || ((state_q == StFlush) && flush_last);
         end
         if (state_q == StEnc) begin
            bit_idx_d = bit_idx_q - 3'd1;
            if (bit_idx_q == 3'd0) begin
               in_full_d   = 1'b0;
               enc_bytes_d = enc_bytes_q + LEN_W'(1);
            end
         end else begin
            flush_cnt_d = flush_cnt_q + FcW'(1);
         end
      end

      if (in_accept) begin
         in_byte_d   = in_data_i;
         in_full_d   = 1'b1;
         bit_idx_d   = 3'd7;
         bytes_acc_d = bytes_acc_q + LEN_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (len_ok) begin
                  mode_d      = mode_i;
                  len_d       = len_bytes_i;
                  st_d        = mode_i ? '0 : tail_in_i;
                  bytes_acc_d = '0;
                  enc_bytes_d = '0;
                  in_full_d   = 1'b0;
                  asm_cnt_d   = '0;
                  flush_cnt_d = '0;
                  state_d     = StEnc;
               end else begin
                  err_len_d = 1'b1;
               end
            end
         end
         StEnc: begin
            if (step && last_enc_bit) begin
               state_d = mode_q ? StFlush : StDrain;
            end
         end
         StFlush: begin
            if (step && flush_last) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (out_accept && out_last_q) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         mode_q      <= 1'b0;
         len_q       <= '0;
         bytes_acc_q <= '0;
         enc_bytes_q <= '0;
         in_byte_q   <= '0;
         in_full_q   <= 1'b0;
         bit_idx_q   <= '0;
         st_q        <= '0;
         asm_q       <= '0;
         asm_cnt_q   <= '0;
         flush_cnt_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         len_q       <= len_d;
         bytes_acc_q <= bytes_acc_d;
         enc_bytes_q <= enc_bytes_d;
         in_byte_q   <= in_byte_d;
         in_full_q   <= in_full_d;
         bit_idx_q   <= bit_idx_d;
         st_q        <= st_d;
         asm_q       <= asm_d;
         asm_cnt_q   <= asm_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         err_len_q   <= err_len_d;
      end
   end

   assign in_ready_o  = in_ready;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = done_q;
   assign err_len_o   = err_len_q;

endmodule

// File: doc/conv_encoder_param.md
Name: conv_encoder_param

Overview:
Parametrised rate-1/N_OUT feed-forward convolutional encoder for the turbo/TBCC transmit chain. It takes MSB-first input bytes over a valid/ready stream and encodes one bit per clock. It supports two runtime modes: tail-biting (initial state preloaded from the block's last K-1 bits) and zero-terminated (zero start state, K-1 flush bits). Output is N_OUT parallel byte lanes on a valid/ready stream with a last flag; there are no internal FIFOs, so downstream buffering is external.

Parameters:
K, 7, constraint length (3..9); state is K-1 bits
N_OUT, 3, number of output streams (1..4)
G0, 7'o133, generator for lane 0, K bits; MSB taps the current input, bit K-1-d taps delay d
G1, 7'o171, generator for lane 1
G2, 7'o165, generator for lane 2
G3, 7'o000, generator for lane 3 (used only if N_OUT=4)
LEN_W, 10, width of the length field
MAX_LEN_BYTES, 768, largest accepted block length in bytes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  block request; sampled only in IDLE
mode  in  1  0 = tail-biting, 1 = zero-terminated; captured on start
len_bytes  in  LEN_W  block length in bytes; captured on start
tail_in  in  K-1  tail-biting preload; tail_in[i] = block bit L-1-i, so bit 0 is the final bit
in_data  in  8  input byte; bit 7 is encoded first
in_valid  in  1  input byte valid
in_ready  out  1  input byte accepted when in_valid & in_ready
out_data  out  8*N_OUT  lane j = out_data[8j+7:8j]; bit 7 is the earliest encoded bit
out_valid  out  1  output group valid
out_ready  in  1  output group consumed when out_valid & out_ready
out_last  out  1  high with the final group of a block
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the final group is consumed
err_len  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset values: all outputs 0, state IDLE, shift state 0, bit counters 0. A reset asserted mid-block aborts the block, and any pending output group is discarded.
- IDLE:
  - start with 1 <= len_bytes <= MAX_LEN_BYTES: capture mode and len_bytes.
  - State preload: tail-biting gives s[d] = tail_in[d-1] for d = 1..K-1; zero-terminated gives s = 0.
  - Move to ENC next cycle.
  - Otherwise (len_bytes = 0 or > MAX_LEN_BYTES): err_len pulses and the block stays in IDLE.
  - start while busy is ignored.
- Encode step (one per cycle):
  - Each lane j produces d_j = XOR over (Gj & {u, s[1..K-1]}).
  - Then shift: s[1] <= u, s[d] <= s[d-1].
  - d_j shifts into lane j's assembly register.
  - The step fires only when an input bit is available and the stall condition is false.
- ENC:
  - in_ready = 1 when the input byte register is empty, or when its bit 0 is being encoded this cycle without stall. This gives back-to-back bytes at full rate (8 cycles per byte).
  - Latency: a byte accepted in cycle t is encoded in cycles t+1..t+8; its group appears with out_valid=1 at t+9.
  - After len_bytes*8 bits: tail-biting goes to DRAIN; zero-terminated goes to FLUSH.
  - in_ready = 0 once len_bytes bytes have been accepted.
- FLUSH:
  - Encode K-1 zero inputs, then pad the assembly register with zeros to the next byte boundary.
  - Pad bits are not encoded bits; they are 0 in every lane.
  - Output bytes per lane: tail-biting = len_bytes; zero-terminated = len_bytes + ceil((K-1)/8).
- Output register:
  - A completed 8-bit group loads the output register and sets out_valid.
  - out_valid holds with stable out_data/out_last until out_ready.
  - Stall: a group completes while out_valid & ~out_ready. The encoder freezes (no step, in_ready = 0) until the output register is accepted.
  - If the output register is accepted in the same cycle a new group completes, the new group loads without a bubble.
- DRAIN: wait for acceptance of the group with out_last=1. done then pulses for one cycle while the state returns to IDLE (busy=0 in the same cycle). start is accepted from the following cycle.
- Tail-biting invariant: the state after the final bit equals the preload state. The bench checks this via an internal probe.

Test Plan:
- Zero-terminated, len=1, in_data=0x80 -> group0 lanes {0xB6, 0xF2, 0xEA}, group1 all 0x00 with out_last=1, then a done pulse.
- Tail-biting, len=1, in_data=0x01, tail_in=6'b000001 -> single group lanes {0x6D, 0xE5, 0xD5}, out_last=1, end state == 6'b000001.
- Tail-biting, len=768, random data, out_ready=1 -> 768 groups matching the C model; in_ready accepts a byte every 8 cycles; first out_valid 9 cycles after the first in handshake.
- Same stream with out_ready toggling randomly 30% low -> identical group sequence; no group lost or duplicated; out_data stable while stalled.
- start with len_bytes=0 and again with 769 -> err_len pulses each time, busy stays 0, no output.
- Reset asserted after 3 groups of a 10-byte block -> next cycle all outputs 0 and state IDLE; a fresh len=1 block then encodes correctly.
